ps2_scancode_rx: RTL and testbench

- PS/2 device-to-host receiver and scancode decoder. It sits directly upstream of the Spectrum key-matrix mapper.
- Converts raw ps2_kbd_clk/ps2_kbd_data pins into one-cycle strobes carrying an 8-bit make/break code with extended and release qualifiers.
- Filters glitches, checks framing and parity, recovers from stalled frames by timeout, and collapses E0/F0/E1 prefix sequences.
- The mapper consumes only {key_strobe, release_btn, extended, code}.

---
 rtl/ps2_pkg.sv | 20 ++
 rtl/ps2_line_filter.sv | 39 +++
 rtl/ps2_scancode_rx.sv | 212 +++++++++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scancode receiver.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam logic [7:0]  PFX_EXT    = 8'hE0;
  localparam logic [7:0]  PFX_REL    = 8'hF0;
  localparam logic [7:0]  PFX_PAUSE  = 8'hE1;
  localparam logic [7:0]  KEY_PAUSE  = 8'h77;
  localparam int unsigned PAUSE_TAIL = 7;

  // Device response bytes that are reported on status_strobe instead of key_strobe.
  function automatic logic is_status(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus FILTER_LEN-deep equality filter for one PS/2 line.
// fall pulses for one cycle when the filtered level goes 1->0.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic fall
);

  logic [1:0]            sync;
  logic [FILTER_LEN-1:0] hist;
  logic [FILTER_LEN-1:0] hist_next;

  assign hist_next = {hist[FILTER_LEN-2:0], sync[1]};

  // Level only moves once the whole history window agrees.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= 2'b11;
      hist  <= '1;
      level <= 1'b1;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], pin};
      hist <= hist_next;
      fall <= 1'b0;
      if (&hist_next) begin
        level <= 1'b1;
      end else if (~|hist_next) begin
        level <= 1'b0;
        fall  <= level;
      end
    end
  end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: filtered pins, 11-bit frame check with timeout, prefix collapsing.
// Define PS2_TYPEMATIC_FILTER_EN to suppress auto-repeated make codes.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_KHZ    = 28000,
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT_US = 2000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_kbd_clk,
  input  logic       ps2_kbd_data,
  output logic       key_strobe,
  output logic [7:0] code,
  output logic       extended,
  output logic       release_btn,
  output logic       status_strobe,
  output logic       frame_err,
  output logic [7:0] err_cnt
);

  localparam int unsigned TO_CYCLES = CLK_KHZ * TIMEOUT_US / 1000;
  localparam int unsigned TO_W      = $clog2(TO_CYCLES + 1);

  logic clk_level, clk_fall, data_level, data_fall, unused_lines;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk(clk_sys), .rst(reset), .pin(ps2_kbd_clk), .level(clk_level), .fall(clk_fall)
  );
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk(clk_sys), .rst(reset), .pin(ps2_kbd_data), .level(data_level), .fall(data_fall)
  );

  assign unused_lines = clk_level ^ data_fall;

  state_t          state_q, state_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      shreg_q, shreg_d, rx_byte_q, rx_byte_d;
  logic            par_q, par_d, rx_vld_q, rx_vld_d, err_d;
  logic [TO_W-1:0] to_q, to_d;

  // Frame FSM: advances only on filtered clock falls; timeout aborts a stalled frame.
  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    rx_vld_d  = 1'b0;
    rx_byte_d = rx_byte_q;
    err_d     = 1'b0;
    to_d      = (state_q == IDLE || clk_fall) ? '0 : to_q + TO_W'(1);
    if (clk_fall) begin
      case (state_q)
        IDLE: if (!data_level) begin
          state_d  = DATA;
          bitcnt_d = 3'd0;
        end
        DATA: begin
          shreg_d  = {data_level, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = data_level;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (data_level && (^{par_q, shreg_q})) begin
            rx_vld_d  = 1'b1;
            rx_byte_d = shreg_q;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && to_q == TO_W'(TO_CYCLES - 1)) begin
      err_d   = 1'b1;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bitcnt_q  <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      to_q      <= '0;
      rx_vld_q  <= 1'b0;
      rx_byte_q <= '0;
      frame_err <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      to_q      <= to_d;
      rx_vld_q  <= rx_vld_d;
      rx_byte_q <= rx_byte_d;
      frame_err <= err_d;
      if (err_d && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  logic       ext_q, ext_d, rel_q, rel_d, repeat_make;
  logic [2:0] pause_q, pause_d;
  logic       key_d, status_d, ext_out_d, rel_out_d;
  logic [7:0] code_d;

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       plain_key, last_vld_q, last_vld_d;
  logic [8:0] last_key_q, last_key_d;

  assign plain_key = rx_vld_q && pause_q == 3'd0 && rx_byte_q != PFX_PAUSE &&
                     rx_byte_q != PFX_EXT && rx_byte_q != PFX_REL && !is_status(rx_byte_q);
  assign repeat_make = !rel_q && last_vld_q && (last_key_q == {ext_q, rx_byte_q});

  // Remember the last make; its own break forgets it.
  always_comb begin
    last_vld_d = last_vld_q;
    last_key_d = last_key_q;
    if (plain_key) begin
      if (!rel_q) begin
        last_vld_d = 1'b1;
        last_key_d = {ext_q, rx_byte_q};
      end else if (last_key_q == {ext_q, rx_byte_q}) begin
        last_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      last_vld_q <= 1'b0;
      last_key_q <= '0;
    end else begin
      last_vld_q <= last_vld_d;
      last_key_q <= last_key_d;
    end
  end
`else
  assign repeat_make = 1'b0;
`endif

  // Byte decoder: Pause tail swallowing, prefix flags, status vs key classification.
  always_comb begin
    ext_d     = ext_q;
    rel_d     = rel_q;
    pause_d   = pause_q;
    key_d     = 1'b0;
    status_d  = 1'b0;
    code_d    = code;
    ext_out_d = extended;
    rel_out_d = release_btn;
    if (rx_vld_q) begin
      if (pause_q != 3'd0) begin
        pause_d = pause_q - 3'd1;
        if (pause_q == 3'd1) begin
          key_d     = 1'b1;
          code_d    = KEY_PAUSE;
          ext_out_d = 1'b1;
          rel_out_d = 1'b0;
        end
      end else if (rx_byte_q == PFX_PAUSE) begin
        pause_d = 3'(PAUSE_TAIL);
      end else if (rx_byte_q == PFX_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte_q == PFX_REL) begin
        rel_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        rel_d = 1'b0;
        if (is_status(rx_byte_q)) begin
          status_d = 1'b1;
          code_d   = rx_byte_q;
        end else if (!repeat_make) begin
          key_d     = 1'b1;
          code_d    = rx_byte_q;
          ext_out_d = ext_q;
          rel_out_d = rel_q;
        end
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ext_q         <= 1'b0;
      rel_q         <= 1'b0;
      pause_q       <= '0;
      key_strobe    <= 1'b0;
      status_strobe <= 1'b0;
      code          <= '0;
      extended      <= 1'b0;
      release_btn   <= 1'b0;
    end else begin
      ext_q         <= ext_d;
      rel_q         <= rel_d;
      pause_q       <= pause_d;
      key_strobe    <= key_d;
      status_strobe <= status_d;
      code          <= code_d;
      extended      <= ext_out_d;
      release_btn   <= rel_out_d;
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Bench for ps2_scancode_rx: PS/2 frames driven onto the pins, outputs checked against a byte-level model.
// Honours PS2_TYPEMATIC_FILTER_EN in the model when the RTL is built with it.
module tb_ps2_scancode_rx;

  // Scaled clock so a 1000 us timeout is 80 clk_sys cycles.
  localparam int unsigned CLK_KHZ    = 80;
  localparam int unsigned FILTER_LEN = 8;
  localparam int unsigned TIMEOUT_US = 1000;
  localparam int unsigned TO_CYCLES  = CLK_KHZ * TIMEOUT_US / 1000;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_kbd_clk = 1'b1;
  logic       ps2_kbd_data = 1'b1;
  logic       key_strobe, extended, release_btn, status_strobe, frame_err;
  logic [7:0] code, err_cnt;

  ps2_scancode_rx #(
    .CLK_KHZ(CLK_KHZ), .FILTER_LEN(FILTER_LEN), .TIMEOUT_US(TIMEOUT_US)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ps2_kbd_clk(ps2_kbd_clk), .ps2_kbd_data(ps2_kbd_data),
    .key_strobe(key_strobe), .code(code), .extended(extended), .release_btn(release_btn),
    .status_strobe(status_strobe), .frame_err(frame_err), .err_cnt(err_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  typedef enum int {EV_KEY, EV_STATUS, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } ev_t;

  ev_t exp_q[$];
  ev_t cur;
  int  n_cmp = 0, n_bad = 0, exp_err = 0, key_seen = 0;
  bit  m_ext, m_rel;
  int  m_pause;
`ifdef PS2_TYPEMATIC_FILTER_EN
  bit         m_last_vld;
  logic [8:0] m_last;
`endif
  logic [7:0] status_list [7] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
  logic [7:0] pause_seq [8]   = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
  logic [7:0] type_seq [5]    = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
  logic [7:0] last_key = 8'h1C;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endfunction

  function automatic void push(input ev_kind_t k, input logic [7:0] c, input bit e, input bit r);
    ev_t ev;
    ev.kind = k; ev.code = c; ev.ext = e; ev.rel = r;
    exp_q.push_back(ev);
  endfunction

  function automatic bit status_byte(input logic [7:0] b);
    return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
  endfunction

  function automatic logic [2:0] kind_bits(input ev_kind_t k);
    case (k)
      EV_KEY:    return 3'b100;
      EV_STATUS: return 3'b010;
      default:   return 3'b001;
    endcase
  endfunction

  // Byte-level reference: what a correctly received byte must produce.
  function automatic void model_byte(input logic [7:0] b);
    bit emit;
    emit = 1'b1;
    if (m_pause > 0) begin
      m_pause--;
      if (m_pause == 0) push(EV_KEY, 8'h77, 1'b1, 1'b0);
    end else if (b == 8'hE1) m_pause = 7;
    else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_rel = 1'b1;
    else if (status_byte(b)) begin
      push(EV_STATUS, b, 1'b0, 1'b0);
      m_ext = 1'b0; m_rel = 1'b0;
    end else begin
`ifdef PS2_TYPEMATIC_FILTER_EN
      if (!m_rel) begin
        if (m_last_vld && m_last == {m_ext, b}) emit = 1'b0;
        m_last_vld = 1'b1; m_last = {m_ext, b};
      end else if (m_last_vld && m_last == {m_ext, b}) m_last_vld = 1'b0;
`endif
      if (emit) push(EV_KEY, b, m_ext, m_rel);
      m_ext = 1'b0; m_rel = 1'b0;
    end
  endfunction

  function automatic logic [7:0] rand_key();
    logic [7:0] b;
    do b = 8'($urandom_range(1, 254));
    while (status_byte(b) || b inside {8'hE0, 8'hE1, 8'hF0});
    return b;
  endfunction

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_sys);
  endtask

  // Device-side bit timing: data changes while clock is high, optional short clock glitches.
  task automatic send_bits(input logic [10:0] frame, input int nbits, input bit glitch);
    for (int i = 0; i < nbits; i++) begin
      ps2_kbd_data = frame[i];
      if (glitch && $urandom_range(0, 1) == 1) begin
        wait_cycles(12);
        ps2_kbd_clk = 1'b0;
        wait_cycles(int'($urandom_range(1, 4)));
        ps2_kbd_clk = 1'b1;
        wait_cycles(12);
      end else begin
        wait_cycles(int'($urandom_range(14, 24)));
      end
      ps2_kbd_clk = 1'b0;
      wait_cycles(int'($urandom_range(14, 24)));
      ps2_kbd_clk = 1'b1;
    end
    wait_cycles(16);
    ps2_kbd_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit glitch);
    model_byte(b);
    send_bits(mk_frame(b, 1'b0, 1'b0), 11, glitch);
  endtask

  task automatic send_bad(input logic [7:0] b, input bit bad_par, input bit glitch);
    push(EV_ERR, 8'h00, 1'b0, 1'b0);
    send_bits(mk_frame(b, bad_par, !bad_par), 11, glitch);
  endtask

  task automatic send_stall(input logic [7:0] b, input int nbits);
    push(EV_ERR, 8'h00, 1'b0, 1'b0);
    send_bits(mk_frame(b, 1'b0, 1'b0), nbits, 1'b0);
    wait_cycles(TO_CYCLES + 20);
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    m_ext = 1'b0; m_rel = 1'b0; m_pause = 0;
`ifdef PS2_TYPEMATIC_FILTER_EN
    m_last_vld = 1'b0;
`endif
    exp_q.delete();
    wait_cycles(n);
    reset = 1'b0;
    wait_cycles(4);
  endtask

  // Compare process: every strobe/error must match the next model event; err_cnt tracked every cycle.
  always @(negedge clk_sys) begin
    if (reset) begin
      chk("reset_outputs", 32'({key_strobe, status_strobe, frame_err, extended, release_btn, code, err_cnt}), 32'd0);
      exp_err = 0;
    end else begin
      if (key_strobe) key_seen++;
      if (key_strobe || status_strobe || frame_err) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event: got key=%0b status=%0b err=%0b code=%02h, want no event",
                   key_strobe, status_strobe, frame_err, code);
        end else begin
          cur = exp_q.pop_front();
          chk("event_kind", 32'({key_strobe, status_strobe, frame_err}), 32'(kind_bits(cur.kind)));
          if (cur.kind != EV_ERR) chk("event_code", 32'(code), 32'(cur.code));
          if (cur.kind == EV_KEY) begin
            chk("event_ext", 32'(extended), 32'(cur.ext));
            chk("event_rel", 32'(release_btn), 32'(cur.rel));
          end
          if (cur.kind == EV_ERR && exp_err < 255) exp_err++;
        end
      end
      chk("err_cnt", 32'(err_cnt), 32'(exp_err));
    end
  end

  initial begin
    repeat (95000) @(posedge clk_sys);
    $display("FAIL watchdog: got cycle budget exhausted, want run complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int k0;
    #1;
    apply_reset(5);
    wait_cycles(20);
    chk("reset_code", 32'(code), 32'h00);

    k0 = key_seen;
    send_byte(8'h1C, 1'b0);
    chk("a_make_code", 32'(code), 32'h1C);
    chk("a_make_flags", 32'({extended, release_btn}), 32'b00);
    chk("a_make_count", key_seen - k0, 1);

    k0 = key_seen;
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    chk("a_break", 32'({extended, release_btn, code}), 32'h11C);
    chk("a_break_count", key_seen - k0, 1);
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h6B, 1'b0);
    chk("ext_break", 32'({extended, release_btn, code}), 32'h36B);

    k0 = key_seen;
    send_bad(8'h1C, 1'b1, 1'b0);
    chk("parity_err_cnt", 32'(err_cnt), 32'd1);
    chk("parity_no_key", key_seen - k0, 0);
    send_byte(8'h29, 1'b0);
    chk("after_parity_code", 32'(code), 32'h29);

    send_stall(8'h5A, 6);
    chk("timeout_err_cnt", 32'(err_cnt), 32'd2);
    send_byte(8'h5A, 1'b0);
    chk("after_timeout_code", 32'(code), 32'h5A);

    k0 = key_seen;
    for (int i = 0; i < 8; i++) send_byte(pause_seq[i], 1'b0);
    chk("pause_count", key_seen - k0, 1);
    chk("pause_key", 32'({extended, release_btn, code}), 32'h277);

    k0 = key_seen;
    send_byte(8'hAA, 1'b0);
    chk("status_code", 32'(code), 32'hAA);
    chk("status_no_key", key_seen - k0, 0);

    k0 = key_seen;
    for (int i = 0; i < 5; i++) send_byte(type_seq[i], 1'b0);
`ifdef PS2_TYPEMATIC_FILTER_EN
    chk("typematic_count", key_seen - k0, 2);
`else
    chk("typematic_count", key_seen - k0, 4);
`endif

    send_bits(mk_frame(8'h33, 1'b0, 1'b0), 4, 1'b0);
    apply_reset(5);
    chk("midreset_err_cnt", 32'(err_cnt), 32'd0);
    send_byte(8'h1C, 1'b0);
    chk("midreset_next", 32'({extended, release_btn, code}), 32'h01C);

    for (int n = 0; n < 40; n++) begin
      int  r;
      bit  g;
      r = int'($urandom_range(0, 99));
      g = ($urandom_range(0, 3) == 0);
      if (r < 8)       send_bad(rand_key(), 1'b1, g);
      else if (r < 12) send_bad(rand_key(), 1'b0, g);
      else if (r < 25) send_byte(8'hE0, g);
      else if (r < 40) send_byte(8'hF0, g);
      else if (r < 45) send_byte(status_list[$urandom_range(0, 6)], g);
      else if (r < 48) send_byte(8'hE1, g);
      else if (r < 60) send_byte(last_key, g);
      else begin
        last_key = rand_key();
        send_byte(last_key, g);
      end
    end

    for (int i = 0; i < 258; i++) send_stall(8'h00, 1);
    chk("err_cnt_saturated", 32'(err_cnt), 32'd255);

    wait_cycles(50);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
